axis_uart_tx_arb: RTL and testbench

AXIS_UART_TX_ARB -- requirements
Module: axis_uart_tx_arb

---
 rtl/axis_uart_pkg.sv | 14 +
 rtl/rr_arb_pick.sv | 30 +++
 rtl/axis_uart_tx_arb.sv | 129 ++++++++++++
 tb/tb_axis_uart_tx_arb.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_uart_pkg.sv
// Shared constants for the AXIS UART TX arbiter: FSM encoding, default
// data width and the round-robin index helper.
package axis_uart_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEF_WIDTH = 8;

    function automatic int rr_slot(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first requester after last grant,
// wrapping modulo N.
module rr_arb_pick
    import axis_uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        int slot;
        found = 1'b0;
        index = '0;
        slot  = 0;
        // Step 1..N so the last grantee is considered only after everyone else.
        for (int k = 1; k <= N; k++) begin
            slot = rr_slot(int'(last), k, N);
            if (!found && req[slot]) begin
                found = 1'b1;
                index = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/axis_uart_tx_arb.sv
// Packet round-robin AXIS arbiter feeding the UART TX path.
// Define AXIS_ARB_WATCHDOG_EN to add the stall watchdog and timeout_err.
module axis_uart_tx_arb
    import axis_uart_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
`ifdef AXIS_ARB_WATCHDOG_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IW = $clog2(NUM_SRC);

    logic [0:0]       state;
    logic [IW-1:0]    last_grant;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             out_ok;
    logic             grant_valid;
    logic             grant_last;
    logic [WIDTH-1:0] grant_data;
    logic             accept;
    logic             wd_fire;

    rr_arb_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req   (s_axis_valid),
        .last  (last_grant),
        .found (pick_found),
        .index (pick_idx)
    );

    assign busy        = (state == ST_BUSY);
    assign out_ok      = !m_axis_valid || m_axis_ready;
    assign grant_valid = s_axis_valid[grant_id];
    assign grant_last  = s_axis_last[grant_id];
    assign grant_data  = s_axis_data[grant_id*WIDTH +: WIDTH];
    assign accept      = busy && out_ok && grant_valid;

    always_comb begin
        s_axis_ready = '0;
        if (busy && out_ok) begin
            s_axis_ready[grant_id] = 1'b1;
        end
    end

`ifdef AXIS_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    // Fires on the TIMEOUT-th consecutive cycle the granted source is idle.
    assign wd_fire = busy && !grant_valid && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_fire;
            if (!busy || accept || wd_fire) begin
                wd_cnt <= '0;
            end else if (!grant_valid) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NUM_SRC - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if ((accept && grant_last) || wd_fire) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register drains on its own, regardless of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
        end else if (accept) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= grant_data;
            m_axis_last  <= grant_last;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Randomized bench for axis_uart_tx_arb with a packet-level round-robin
// model; also covers the watchdog when AXIS_ARB_WATCHDOG_EN is defined.
module tb_axis_uart_tx_arb;

    localparam int W    = 8;
    localparam int NSRC = 3;
    localparam int TO   = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       first;
        int         src;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSRC*W-1:0] s_data;
    logic [NSRC-1:0]   s_valid;
    logic [NSRC-1:0]   s_last;
    logic [NSRC-1:0]   s_ready;
    logic [W-1:0]      m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef AXIS_ARB_WATCHDOG_EN
    logic              timeout_err;
`endif

    always #5 clk = ~clk;

    axis_uart_tx_arb #(
        .WIDTH   (W),
        .NUM_SRC (NSRC),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_last  (s_last),
        .s_axis_ready (s_ready),
        .m_axis_data  (m_data),
        .m_axis_valid (m_valid),
        .m_axis_last  (m_last),
        .m_axis_ready (m_ready),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef AXIS_ARB_WATCHDOG_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    beat_t pend[NSRC][$];
    beat_t srcq[NSRC][$];
    beat_t exp_q[$];
    int    in_idx, out_idx, model_last, cyc;
    int    passed, total;
    int    rdy_mode;
    bit    gap_en;
    logic [NSRC-1:0] hs_q;

    logic [7:0] out_log[$];
    logic       out_last_log[$];
    int         out_cyc[$];
    int         in_src[$];
    int         in_cyc[$];
    int         to_cyc[$];

    function automatic void chk(string nm, bit ok, longint act, longint exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic void add_pkt(int s, int n, int base, bit term = 1'b1);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = (base < 0) ? 8'($urandom) : 8'(base + i);
            b.last  = term && (i == n - 1);
            b.first = (i == 0);
            b.src   = s;
            pend[s].push_back(b);
        end
    endfunction

    // Whole packets are served in rotation starting after the last grantee.
    function automatic void plan();
        int    cur;
        bit    any;
        beat_t b;
        cur = model_last;
        while (1) begin
            any = 1'b0;
            for (int k = 1; k <= NSRC; k++) begin
                int j;
                j = (cur + k) % NSRC;
                if (pend[j].size() > 0) begin
                    do begin
                        b = pend[j].pop_front();
                        srcq[j].push_back(b);
                        exp_q.push_back(b);
                    end while (!b.last && pend[j].size() > 0);
                    cur = j;
                    any = 1'b1;
                    break;
                end
            end
            if (!any) break;
        end
        model_last = cur;
    endfunction

    function automatic void clear_logs();
        out_log.delete();
        out_last_log.delete();
        out_cyc.delete();
        in_src.delete();
        in_cyc.delete();
        to_cyc.delete();
    endfunction

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (!(out_idx == exp_q.size() && !busy && !m_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < budget, n, budget);
        chk("all_accepted", in_idx == exp_q.size(), in_idx, exp_q.size());
        @(negedge clk);
    endtask

    // Source and sink driver: one update per cycle, just after the edge.
    initial begin
        beat_t b;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NSRC; i++) begin
                if (hs_q[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (rst || srcq[i].size() == 0) begin
                    s_valid[i] = 1'b0;
                end else begin
                    b = srcq[i][0];
                    s_data[i*W +: W] = b.data;
                    s_last[i] = b.last;
                    if (b.first || !gap_en || (s_valid[i] && !hs_q[i]))
                        s_valid[i] = 1'b1;
                    else
                        s_valid[i] = ($urandom_range(0, 3) != 0);
                end
            end
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Compare process against the model, every cycle outside reset.
    initial begin
        logic [NSRC-1:0] exp_rdy;
        bit         p_in_hs, p_stall, n_in_hs;
        logic [7:0] p_in_data, p_data;
        logic       p_in_last, p_last;
        p_in_hs = 0;
        p_stall = 0;
        hs_q    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                p_in_hs = 0;
                p_stall = 0;
                hs_q    = '0;
            end else begin
                exp_rdy = (busy && (!m_valid || m_ready)) ? (NSRC'(1) << grant_id) : '0;
                chk("s_ready", s_ready === exp_rdy, s_ready, exp_rdy);
                if (p_in_hs) begin
                    chk("lat_valid", m_valid === 1'b1, m_valid, 1);
                    chk("lat_data", m_data === p_in_data, m_data, p_in_data);
                    chk("lat_last", m_last === p_in_last, m_last, p_in_last);
                end
                if (p_stall) begin
                    chk("hold_valid", m_valid === 1'b1, m_valid, 1);
                    chk("hold_data", m_data === p_data, m_data, p_data);
                    chk("hold_last", m_last === p_last, m_last, p_last);
                end
                n_in_hs = 0;
                for (int i = 0; i < NSRC; i++) begin
                    hs_q[i] = s_valid[i] && s_ready[i];
                    if (hs_q[i]) begin
                        n_in_hs = 1;
                        chk("in_extra", in_idx < exp_q.size(), in_idx, exp_q.size());
                        if (in_idx < exp_q.size()) begin
                            chk("in_src", i == exp_q[in_idx].src, i, exp_q[in_idx].src);
                            chk("in_data", s_data[i*W +: W] === exp_q[in_idx].data,
                                s_data[i*W +: W], exp_q[in_idx].data);
                            chk("in_last", s_last[i] === exp_q[in_idx].last,
                                s_last[i], exp_q[in_idx].last);
                        end
                        in_idx++;
                        in_src.push_back(i);
                        in_cyc.push_back(cyc);
                        p_in_data = s_data[i*W +: W];
                        p_in_last = s_last[i];
                    end
                end
                if (m_valid && m_ready) begin
                    chk("out_extra", out_idx < exp_q.size(), out_idx, exp_q.size());
                    if (out_idx < exp_q.size()) begin
                        chk("out_data", m_data === exp_q[out_idx].data, m_data, exp_q[out_idx].data);
                        chk("out_last", m_last === exp_q[out_idx].last, m_last, exp_q[out_idx].last);
                    end
                    out_idx++;
                    out_log.push_back(m_data);
                    out_last_log.push_back(m_last);
                    out_cyc.push_back(cyc);
                end
`ifdef AXIS_ARB_WATCHDOG_EN
                if (timeout_err) to_cyc.push_back(cyc);
`endif
                p_in_hs = n_in_hs;
                p_stall = m_valid && !m_ready;
                p_data  = m_data;
                p_last  = m_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst        = 1'b0;
        rdy_mode   = 0;
        gap_en     = 0;
        model_last = NSRC - 1;
        in_idx     = 0;
        out_idx    = 0;
        passed     = 0;
        total      = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", m_valid === 1'b0, m_valid, 0);
        chk("rst_data", m_data === 8'h00, m_data, 0);
        chk("rst_last", m_last === 1'b0, m_last, 0);
        chk("rst_busy", busy === 1'b0, busy, 0);
        chk("rst_grant", grant_id === 2'd0, grant_id, 0);
        chk("rst_ready", s_ready === 3'b000, s_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two simultaneous requesters straight from reset.
        clear_logs();
        add_pkt(0, 2, 8'h01);
        add_pkt(1, 2, 8'h03);
        add_pkt(0, 2, 8'h05);
        add_pkt(1, 2, 8'h07);
        plan();
        wait_done(100);
        chk("rr_count", out_log.size() == 8, out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("rr_data", out_log[i] === 8'(i + 1), out_log[i], i + 1);
        for (int i = 0; i < 8 && i < in_src.size(); i++)
            chk("rr_grant", in_src[i] == (i / 2) % 2, in_src[i], (i / 2) % 2);

        // Three-byte packet at full rate.
        clear_logs();
        add_pkt(0, 3, 8'h41);
        plan();
        wait_done(50);
        chk("p3_count", out_log.size() == 3, out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("p3_b0", out_log[0] === 8'h41 && out_last_log[0] === 1'b0, out_log[0], 8'h41);
            chk("p3_b1", out_log[1] === 8'h42 && out_last_log[1] === 1'b0, out_log[1], 8'h42);
            chk("p3_b2", out_log[2] === 8'h43 && out_last_log[2] === 1'b1, out_log[2], 8'h43);
            chk("p3_consec", out_cyc[2] - out_cyc[0] == 2, out_cyc[2] - out_cyc[0], 2);
        end
        chk("p3_busy_low", busy === 1'b0, busy, 0);

        // Lone persistent requester: one idle cycle between grants.
        clear_logs();
        add_pkt(0, 1, 8'h11);
        add_pkt(0, 1, 8'h12);
        plan();
        wait_done(50);
        if (in_cyc.size() == 2)
            chk("regrant_gap", in_cyc[1] - in_cyc[0] == 2, in_cyc[1] - in_cyc[0], 2);
        else
            chk("regrant_cnt", in_cyc.size() == 2, in_cyc.size(), 2);

        // Downstream stall with 0x55 pending.
        clear_logs();
        add_pkt(0, 3, 8'h54);
        plan();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(m_valid && m_data == 8'h55) && n < 40);
        chk("stall_seen", n < 40, n, 40);
        rdy_mode = 2;
        m_ready  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", m_data === 8'h55 && m_valid === 1'b1, m_data, 8'h55);
            chk("stall_ready", s_ready === 3'b000, s_ready, 0);
        end
        rdy_mode = 0;
        wait_done(50);
        chk("stall_count", out_log.size() == 3, out_log.size(), 3);
        if (out_log.size() == 3)
            chk("stall_seq", {out_log[0], out_log[1], out_log[2]} === 24'h545556,
                {out_log[0], out_log[1], out_log[2]}, 24'h545556);

        // Reset in the middle of a packet.
        add_pkt(0, 4, 8'h10);
        add_pkt(1, 2, 8'h20);
        plan();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (in_idx < 2 && n < 40);
        rst = 1'b1;
        #1;
        chk("mrst_valid", m_valid === 1'b0, m_valid, 0);
        chk("mrst_data", m_data === 8'h00, m_data, 0);
        chk("mrst_last", m_last === 1'b0, m_last, 0);
        chk("mrst_busy", busy === 1'b0, busy, 0);
        chk("mrst_grant", grant_id === 2'd0, grant_id, 0);
        chk("mrst_ready", s_ready === 3'b000, s_ready, 0);
        for (int i = 0; i < NSRC; i++) begin
            srcq[i].delete();
            pend[i].delete();
        end
        exp_q.delete();
        in_idx     = 0;
        out_idx    = 0;
        model_last = NSRC - 1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        clear_logs();
        add_pkt(1, 1, 8'h30);
        add_pkt(0, 1, 8'h31);
        plan();
        wait_done(50);
        if (in_src.size() > 0)
            chk("post_rst_src0", in_src[0] == 0, in_src[0], 0);
        if (out_log.size() == 2)
            chk("post_rst_seq", {out_log[0], out_log[1]} === 16'h3130,
                {out_log[0], out_log[1]}, 16'h3130);
        else
            chk("post_rst_cnt", out_log.size() == 2, out_log.size(), 2);

        // Random packets, source gaps and downstream backpressure.
        rdy_mode = 1;
        gap_en   = 1;
        for (int r = 0; r < 10; r++) begin
            for (int s = 0; s < NSRC; s++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    add_pkt(s, $urandom_range(1, 4), -1);
            end
            plan();
            wait_done(800);
        end
        rdy_mode = 0;
        gap_en   = 0;

`ifdef AXIS_ARB_WATCHDOG_EN
        // Source 1 stalls forever after one beat without last.
        clear_logs();
        add_pkt(1, 1, 8'h77, 1'b0);
        begin
            beat_t b;
            b = pend[1].pop_front();
            srcq[1].push_back(b);
            exp_q.push_back(b);
        end
        repeat (40) @(negedge clk);
        chk("wd_pulses", to_cyc.size() == 1, to_cyc.size(), 1);
        if (to_cyc.size() == 1 && in_cyc.size() == 1)
            chk("wd_delay", to_cyc[0] - in_cyc[0] == TO + 1, to_cyc[0] - in_cyc[0], TO + 1);
        chk("wd_idle", busy === 1'b0, busy, 0);
        model_last = 1;
        add_pkt(0, 1, 8'h78);
        plan();
        wait_done(50);
        chk("wd_next_src", in_src.size() == 2 && in_src[1] == 0, in_src.size(), 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
